// File: rtl/mem_test_pkg.sv
// Shared types and constants for the memory-test sequencer and its pattern generator.
package mem_test_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   localparam logic PH_TRUE = 1'b0;
   localparam logic PH_INV  = 1'b1;

   // Two phases of DEPTH compares each need ADDR_W+1 bits; one spare keeps the
   // counter clear of wrap even at the maximum count.
   function automatic int err_cnt_w(input int addr_w);
      return addr_w + 2;
   endfunction

endpackage

// File: rtl/mem_pattern_gen.sv
// Test pattern P(a, ph) = zero-extended address XOR seed, inverted in the complement phase.
module mem_pattern_gen #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              ph_i,
   input  logic [DATA_W-1:0] seed_i,
   output logic [DATA_W-1:0] pat_o
);

   logic [DATA_W-1:0] addr_ext;

   assign addr_ext = DATA_W'(addr_i);
   assign pat_o    = (addr_ext ^ seed_i) ^ {DATA_W{ph_i}};

endmodule

// File: rtl/mem_test_ctrl.sv
// Write/read-back memory test sequencer: two pattern phases, mismatch counting and
// first-failure capture, with expected words presented to an external comparator.
module mem_test_ctrl
   import mem_test_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [DATA_W-1:0]            seed,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [err_cnt_w(ADDR_W)-1:0] err_cnt,
   output logic [ADDR_W-1:0]            fail_addr,
   output logic                         fail_phase,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic                         mem_we,
   output logic                         mem_re,
   output logic [DATA_W-1:0]            mem_wdata,
   output logic [DATA_W-1:0]            data_gen,
   input  logic                         is_equal
);

   localparam int                ERR_W     = err_cnt_w(ADDR_W);
   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

   state_e              state_q, state_d;
   logic                ph_q, ph_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   seed_q, seed_d;
   logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
   logic                cmp_vld_q, cmp_vld_d;
   logic [DATA_W-1:0]   gen_hold_q;
   logic [ERR_W-1:0]    err_q, err_d;
   logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
   logic                fail_phase_q, fail_phase_d;
   logic                pass_q, pass_d;
   logic [DATA_W-1:0]   wr_pat;
   logic [DATA_W-1:0]   cmp_pat;

   mem_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wr_pat (
      .addr_i (addr_q),
      .ph_i   (ph_q),
      .seed_i (seed_q),
      .pat_o  (wr_pat)
   );

   mem_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_cmp_pat (
      .addr_i (cmp_addr_q),
      .ph_i   (ph_q),
      .seed_i (seed_q),
      .pat_o  (cmp_pat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ph_q         <= PH_TRUE;
         addr_q       <= '0;
         seed_q       <= '0;
         cmp_addr_q   <= '0;
         cmp_vld_q    <= 1'b0;
         gen_hold_q   <= '0;
         err_q        <= '0;
         fail_addr_q  <= '0;
         fail_phase_q <= PH_TRUE;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ph_q         <= ph_d;
         addr_q       <= addr_d;
         seed_q       <= seed_d;
         cmp_addr_q   <= cmp_addr_d;
         cmp_vld_q    <= cmp_vld_d;
         gen_hold_q   <= data_gen;
         err_q        <= err_d;
         fail_addr_q  <= fail_addr_d;
         fail_phase_q <= fail_phase_d;
         pass_q       <= pass_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ph_d         = ph_q;
      addr_d       = addr_q;
      seed_d       = seed_q;
      cmp_addr_d   = addr_q;
      cmp_vld_d    = 1'b0;
      err_d        = err_q;
      fail_addr_d  = fail_addr_q;
      fail_phase_d = fail_phase_q;
      pass_d       = pass_q;
      busy         = 1'b0;
      done         = 1'b0;
      mem_we       = 1'b0;
      mem_re       = 1'b0;
      mem_wdata    = '0;

      // A compare slot always trails the read that fed it by one cycle.
      if (cmp_vld_q && !is_equal) begin
         err_d = err_q + ERR_W'(1);
         if (err_q == '0) begin
            fail_addr_d  = cmp_addr_q;
            fail_phase_d = ph_q;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               seed_d       = seed;
               err_d        = '0;
               fail_addr_d  = '0;
               fail_phase_d = PH_TRUE;
               pass_d       = 1'b0;
               ph_d         = PH_TRUE;
               addr_d       = '0;
               state_d      = S_WRITE;
            end
         end
         S_WRITE: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = wr_pat;
            addr_d    = addr_q + 1'b1;
            if (addr_q == ADDR_LAST) state_d = S_READ;
         end
         S_READ: begin
            busy      = 1'b1;
            mem_re    = 1'b1;
            cmp_vld_d = 1'b1;
            addr_d    = addr_q + 1'b1;
            if (addr_q == ADDR_LAST) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (ph_q == PH_TRUE) begin
               ph_d    = PH_INV;
               addr_d  = '0;
               state_d = S_WRITE;
            end else begin
               // err_d already folds in the final compare made this cycle.
               pass_d  = (err_d == '0);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_addr   = addr_q;
   assign data_gen   = cmp_vld_q ? cmp_pat : gen_hold_q;
   assign err_cnt    = err_q;
   assign fail_addr  = fail_addr_q;
   assign fail_phase = fail_phase_q;
   assign pass       = pass_q;

endmodule
